// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: default width and FSM encoding.
package seq_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_LEN_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/seq_len_clamp.sv
// Normalises a requested pattern length: 0 or anything above DATA_W selects DATA_W.
module seq_len_clamp
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic [SEQ_LEN_W-1:0] len_in,
  output logic [SEQ_LEN_W-1:0] len_out
);

  localparam logic [SEQ_LEN_W-1:0] MAX_LEN = SEQ_LEN_W'(DATA_W);

  always_comb begin
    len_out = len_in;
    if (len_in == '0 || len_in > MAX_LEN) len_out = MAX_LEN;
  end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: shifts out a loaded pattern MSB-first, optionally looping,
// with a one-cycle done pulse at the end of a non-repeating run.
module seq_gen
  import seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] pat_in,
  input  logic [4:0]        len_in,
  input  logic              start,
  input  logic              repeat_en,
  input  logic              stop,
  output logic              seq_bit,
  output logic              bit_vld,
  output logic [4:0]        bit_idx,
  output logic              busy,
  output logic              done
);

  seq_state_e        state;
  logic [DATA_W-1:0] pat_r;
  logic [4:0]        len_r;
  logic [4:0]        len_clamp;

  seq_len_clamp #(.DATA_W(DATA_W)) u_clamp (
    .len_in  (len_in),
    .len_out (len_clamp)
  );

  // Widened copies so the 5-bit bit positions index without width games.
  logic [31:0] pat_ext, run_pat_ext;
  logic [4:0]  run_len, run_first, first_pos, nxt_pos;
  logic        last;

  always_comb begin
    // A start that coincides with load sends the freshly presented pattern.
    run_pat_ext = 32'(load ? pat_in : pat_r);
    run_len     = load ? len_clamp : len_r;
    run_first   = run_len - 5'd1;
    pat_ext     = 32'(pat_r);
    first_pos   = len_r - 5'd1;
    nxt_pos     = len_r - 5'd2 - bit_idx;
    last        = (bit_idx == first_pos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pat_r   <= '0;
      len_r   <= 5'(DATA_W);
      seq_bit <= 1'b0;
      bit_vld <= 1'b0;
      bit_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            pat_r <= pat_in;
            len_r <= len_clamp;
          end
          if (start) begin
            state   <= ST_SEND;
            busy    <= 1'b1;
            bit_vld <= 1'b1;
            bit_idx <= '0;
            seq_bit <= run_pat_ext[run_first];
          end
        end
        ST_SEND: begin
          if (stop) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bit_vld <= 1'b0;
            bit_idx <= '0;
            seq_bit <= 1'b0;
          end else if (last && repeat_en) begin
            bit_idx <= '0;
            seq_bit <= pat_ext[first_pos];
          end else if (last) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            bit_vld <= 1'b0;
            bit_idx <= '0;
            seq_bit <= 1'b0;
          end else begin
            bit_idx <= bit_idx + 5'd1;
            seq_bit <= pat_ext[nxt_pos];
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          bit_vld <= 1'b0;
          bit_idx <= '0;
          seq_bit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter: DATA_W, 16, maximum pattern length in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load  input  1  capture pat_in/len_in into shadow registers.
REQ-005 SHALL have port: pat_in  input  DATA_W  pattern, bit [len-1] transmitted first.
REQ-006 SHALL have port: len_in  input  5  pattern length; 0 or >DATA_W means DATA_W.
REQ-007 SHALL have port: start  input  1  begin transmission (single-cycle pulse).
REQ-008 SHALL have port: repeat_en  input  1  loop pattern continuously while high.
REQ-009 SHALL have port: stop  input  1  abort transmission.
REQ-010 SHALL have port: seq_bit  output  1  serial data bit.
REQ-011 SHALL have port: bit_vld  output  1  seq_bit carries a pattern bit this cycle.
REQ-012 SHALL have port: bit_idx  output  5  position in pattern of current bit, 0 = first.
REQ-013 SHALL have port: busy  output  1  state is SEND or DONE.
REQ-014 SHALL have port: done  output  1  one-cycle pulse after last bit of a non-repeating run.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, DONE; all outputs registered.
REQ-016 SHALL capture pat_in and clamped len_in on load only in IDLE; load while busy is ignored.
REQ-017 SHALL, on start in IDLE, enter SEND next cycle with seq_bit = pat[len-1], bit_vld=1, bit_idx=0.
REQ-018 SHALL, when load and start coincide in IDLE, transmit the newly presented pat_in/len_in.
REQ-019 SHALL, in SEND, emit one bit per cycle, bit_idx incrementing, seq_bit = pat[len-1-bit_idx].
REQ-020 SHALL, on last bit (bit_idx = len-1) with repeat_en=1, wrap to bit_idx=0 next cycle with no gap cycle.
REQ-021 SHALL, on last bit with repeat_en=0, enter DONE: done=1, bit_vld=0, seq_bit=0 for one cycle, then IDLE.
REQ-022 SHALL, on stop in SEND or DONE, enter IDLE next cycle with no done pulse; stop outranks repeat_en and wrap.
REQ-023 SHALL ignore start while busy; stop in IDLE has no effect.
REQ-024 SHALL drive seq_bit=0 and bit_idx=0 whenever bit_vld=0.
REQ-025 SHALL handle len=1: single-bit run, or constant stream of that bit under repeat_en.
REQ-026 SHALL give run latency start -> first bit = 1 cycle; start -> done = len+1 cycles.

Reset
REQ-027 SHALL on rst_n low asynchronously set state IDLE, seq_bit=0, bit_vld=0, bit_idx=0, busy=0, done=0.
REQ-028 SHALL reset shadow pattern to 0 and shadow length to DATA_W.
REQ-029 SHALL, when reset occurs mid-run, abort without done pulse; first cycle after release is IDLE.

Structure
REQ-030 SHALL place state encoding (IDLE=2'b00, SEND=2'b01, DONE=2'b10) and DATA_W default in shared package seq_pkg.
REQ-031 SHALL be single module; optional sub-module seq_len_clamp for len_in normalisation.

Verification
REQ-032 SHALL test: load pat=16'h0016, len=5, start -> seq_bit 1,0,1,1,0 cycles 1-5, done at cycle 6, busy low cycle 7.
REQ-033 SHALL test: same pattern, repeat_en=1 for 3 runs -> 15 contiguous valid bits; a 10110 detector loopback flags 3 hits.
REQ-034 SHALL test: len_in=0, pat=16'h0D95, start -> 16 bits 0000_1101_1001_0101 MSB first, done at cycle 17.
REQ-035 SHALL test: stop at bit_idx=2 -> IDLE next cycle, bit_vld=0, no done; start during SEND ignored; load during SEND leaves shadow unchanged.
REQ-036 SHALL test: rst_n low at bit_idx=3 -> all outputs 0 immediately; new start after release transmits from bit_idx=0.
